// File: rtl/equiv_checker.sv
// rtl/equiv_checker.sv - exhaustive-vector equivalence checker for a reference vs. simplified circuit
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             single-cycle pulse: clear results and begin a run
//   in_valid/in_ready sample handshake (in_ready only while collecting)
//   in_vec            applied input vector, index into coverage
//   f_ref, f_dut      reference and simplified circuit outputs for in_vec
//   busy, done, pass  run status; pass = done with no mismatches
//   mismatch_cnt      saturating count of accepted mismatching samples
//   first_fail_vec    in_vec of the first mismatch, qualified by first_fail_valid
//   coverage          bit i set once vector i has been accepted
module equiv_checker #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       in_vec,
    input  logic                  f_ref,
    input  logic                  f_dut,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic                  first_fail_valid,
    output logic [(1<<N_IN)-1:0]  coverage
);

    localparam int N_VEC = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             miss;
    logic [N_VEC-1:0] cov_set;
    logic [N_VEC-1:0] cov_next;

    // start always wins over a coincident handshake, so the sample is dropped
    always_comb begin
        accept     = (state == COLLECT) && in_valid && !start;
        miss       = accept && (f_ref != f_dut);
        cov_set    = N_VEC'(1) << in_vec;
        cov_next   = coverage | cov_set;
        state_next = state;
        if (start) begin
            state_next = COLLECT;
        end else if (accept && (&cov_next)) begin
            // the completing accept moves to DONE on the same edge
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coverage         <= '0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (start) begin
            coverage         <= '0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            coverage <= cov_next;
            if (miss) begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_vec   <= in_vec;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

    assign in_ready = (state == COLLECT);
    assign busy     = (state == COLLECT);
    assign done     = (state == DONE);
    assign pass     = done && (mismatch_cnt == '0) && !first_fail_valid;

endmodule

// File: tb/tb_equiv_checker.sv
// tb/tb_equiv_checker.sv - directed self-checking bench for equiv_checker
module tb_equiv_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [2:0] in_vec;
    logic       f_ref;
    logic       f_dut;

    logic       in_ready, busy, done, pass, ffv;
    logic [7:0] cnt;
    logic [2:0] ffvec;
    logic [7:0] cov;

    logic       s_in_ready, s_busy, s_done, s_pass, s_ffv;
    logic [1:0] s_cnt;
    logic [2:0] s_ffvec;
    logic [7:0] s_cov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    equiv_checker #(.N_IN(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_vec(in_vec), .f_ref(f_ref), .f_dut(f_dut),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(cnt),
        .first_fail_vec(ffvec), .first_fail_valid(ffv), .coverage(cov)
    );

    equiv_checker #(.N_IN(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_vec(in_vec), .f_ref(f_ref), .f_dut(f_dut),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_cnt(s_cnt),
        .first_fail_vec(s_ffvec), .first_fail_valid(s_ffv), .coverage(s_cov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs set before the call are sampled at this edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // reference function is parity; flip injects a mismatch on the dut side
    task automatic send(input logic [2:0] v, input logic flip);
        in_valid = 1'b1; in_vec = v;
        f_ref = ^v; f_dut = (^v) ^ flip;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_vec = '0; f_ref = 1'b0; f_dut = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ffv", ffv, 0);
        chk("rst_ffvec", ffvec, 0);
        chk("rst_cov", cov, 0);
        rst_n = 1'b1;
        step();

        // idle ignores samples
        send(3'd2, 1'b1);
        chk("idle_cov", cov, 0);
        chk("idle_cnt", cnt, 0);

        // clean sweep 0..7
        pulse_start();
        chk("a_busy", busy, 1);
        chk("a_ready", in_ready, 1);
        for (int v = 0; v < 7; v++) send(3'(v), 1'b0);
        chk("a_done_pre", done, 0);
        chk("a_cov_pre", cov, 8'h7F);
        send(3'd7, 1'b0);
        chk("a_done", done, 1);
        chk("a_pass", pass, 1);
        chk("a_cnt", cnt, 0);
        chk("a_cov", cov, 8'hFF);
        chk("a_busy_off", busy, 0);
        chk("a_ready_off", in_ready, 0);
        send(3'd1, 1'b1);
        chk("a_hold_cnt", cnt, 0);
        chk("a_hold_pass", pass, 1);

        // mismatches at 3 and 6
        pulse_start();
        chk("b_clr_cov", cov, 0);
        for (int v = 0; v < 8; v++) send(3'(v), (v == 3) || (v == 6));
        chk("b_cnt", cnt, 2);
        chk("b_ffvec", ffvec, 3);
        chk("b_ffv", ffv, 1);
        chk("b_pass", pass, 0);
        chk("b_done", done, 1);

        // 0..6 with a mismatching duplicate of 5, then 7
        pulse_start();
        for (int v = 0; v < 6; v++) send(3'(v), 1'b0);
        send(3'd5, 1'b1);
        send(3'd6, 1'b0);
        chk("c_done", done, 0);
        chk("c_cov", cov, 8'h7F);
        chk("c_cnt", cnt, 1);
        chk("c_ffvec", ffvec, 5);
        send(3'd7, 1'b0);
        chk("c_done2", done, 1);
        chk("c_pass", pass, 0);

        // reset mid-run
        pulse_start();
        for (int v = 0; v < 4; v++) send(3'(v), v == 1);
        chk("d_cov_pre", cov, 8'h0F);
        #2 rst_n = 1'b0;
        #1;
        chk("d_busy", busy, 0);
        chk("d_ready", in_ready, 0);
        chk("d_done", done, 0);
        chk("d_cnt", cnt, 0);
        chk("d_cov", cov, 0);
        chk("d_ffv", ffv, 0);
        chk("d_ffvec", ffvec, 0);
        rst_n = 1'b1;
        step();
        send(3'd4, 1'b1);
        chk("d_idle_ready", in_ready, 0);
        chk("d_idle_cov", cov, 0);

        // saturation on the 2-bit counter, then start beats a handshake
        pulse_start();
        for (int i = 0; i < 6; i++) send(3'd0, 1'b1);
        chk("e_sat_cnt", s_cnt, 3);
        chk("e_wide_cnt", cnt, 6);
        chk("e_sat_cov", s_cov, 8'h01);
        start = 1'b1; in_valid = 1'b1; in_vec = 3'd5;
        f_ref = 1'b0; f_dut = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("e_clr_cnt", s_cnt, 0);
        chk("e_clr_cov", s_cov, 0);
        chk("e_clr_ffv", s_ffv, 0);
        chk("e_wide_clr", cnt, 0);
        chk("e_busy", s_busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/equiv_checker.md
EQUIV_CHECKER -- requirements
Module: equiv_checker

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the width of the applied input vector.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the mismatch counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  single-cycle pulse that begins a new check run.
REQ-007 Port in_valid  input  1  sample-present qualifier.
REQ-008 Port in_ready  output  1  block can accept a sample.
REQ-009 Port in_vec  input  N_IN  input vector applied to both circuits under comparison.
REQ-010 Port f_ref  input  1  reference (original) circuit output for in_vec.
REQ-011 Port f_dut  input  1  simplified circuit output for in_vec.
REQ-012 Port busy  output  1  run in progress.
REQ-013 Port done  output  1  all 2^N_IN vectors covered.
REQ-014 Port pass  output  1  done with zero mismatches.
REQ-015 Port mismatch_cnt  output  CNT_W  number of accepted mismatching samples, saturating.
REQ-016 Port first_fail_vec  output  N_IN  in_vec of the first mismatching sample.
REQ-017 Port first_fail_valid  output  1  first_fail_vec holds a captured value.
REQ-018 Port coverage  output  2^N_IN  bit i set once vector i has been accepted.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-020 Transitions: IDLE --start--> COLLECT; COLLECT --coverage becomes all-ones--> DONE; DONE --start--> COLLECT; any state except IDLE --start--> COLLECT.
REQ-021 On the start edge, coverage, mismatch_cnt, first_fail_vec and first_fail_valid SHALL clear to 0 and the state SHALL become COLLECT.
REQ-022 in_ready SHALL be 1 only in COLLECT; busy SHALL equal (state==COLLECT); done SHALL equal (state==DONE).
REQ-023 A sample SHALL be accepted on a rising edge where in_valid and in_ready are both 1 and start is 0.
REQ-024 On accept, coverage[in_vec] SHALL be set to 1 at that edge; a repeated vector leaves coverage unchanged.
REQ-025 On accept with f_ref != f_dut, mismatch_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 On accept with f_ref != f_dut and first_fail_valid==0, first_fail_vec SHALL capture in_vec and first_fail_valid SHALL be set; later mismatches SHALL NOT overwrite it.
REQ-027 The accept that completes coverage SHALL move the state to DONE on the same edge; done therefore rises the cycle after the final handshake, and mismatch_cnt already includes that sample.
REQ-028 pass SHALL equal done AND (mismatch_cnt==0) AND NOT first_fail_valid.
REQ-029 If start and an in_valid handshake coincide, start SHALL win and the sample SHALL be discarded.
REQ-030 In IDLE and DONE, in_valid SHALL be ignored and all result outputs SHALL hold.
REQ-031 Duplicate vectors SHALL still be compared and counted for mismatches.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE; busy, done, pass, in_ready, first_fail_valid=0; mismatch_cnt=0; first_fail_vec=0; coverage=0.
REQ-033 Reset asserted mid-run SHALL abandon the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 Start, then vectors 0..7 in order at one per cycle with f_ref==f_dut -> done=1 one cycle after vec 7, pass=1, mismatch_cnt=0, coverage=8'hFF.
REQ-035 Same run with f_dut inverted at vectors 3 and 6 -> mismatch_cnt=2, first_fail_vec=3, first_fail_valid=1, pass=0, done=1.
REQ-036 Vectors 0..6 applied, vec 5 repeated with a mismatch -> done=0, coverage=8'h7F, mismatch_cnt=1; then vec 7 -> done=1, pass=0.
REQ-037 Assert rst_n low after 4 accepted samples -> all outputs 0 immediately, state IDLE, in_ready=0 until the next start.
REQ-038 With CNT_W=2, 6 mismatching duplicate samples -> mismatch_cnt saturates at 3; start with in_valid=1 in the same cycle -> counters clear and the sample is not counted.
